// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and data-memory bus between the execute stage,
// mem_access_ctrl and the 16-bit data memory.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] readAddress;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;

  // Controller side: accepts requests, drives the memory strobes.
  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready, readData,
    output req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, readAddress, writeAddress, writeData
  );

  // Datapath/memory side.
  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, resp_ready, readData,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           MemRead, MemWrite, readAddress, writeAddress, writeData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the 16-bit data memory: one request at a time, strobe
// sequencing, response with error flag. BYTE_ACCESS_EN adds byte loads and RMW byte stores.
module mem_access_ctrl #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = 100
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

`ifdef BYTE_ACCESS_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RESP   = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RESP   = 3'd3
  } state_t;
`endif

  state_t            state;
  logic              reqReady;
  logic              respValid;
  logic [DATA_W-1:0] respRdata;
  logic              respErr;
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  logic              isByte;
  logic              reqErr;
  logic [ADDR_W-1:0] alignedAddr;

`ifdef BYTE_ACCESS_EN
  logic              latByte;
  logic              latOdd;
  logic [7:0]        latWbyte;

  // Odd byte address selects the upper lane of the word.
  function automatic logic [DATA_W-1:0] pickByte(input logic [DATA_W-1:0] word, input logic odd);
    pickByte = odd ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
  endfunction

  function automatic logic [DATA_W-1:0] mergeByte(input logic [DATA_W-1:0] word,
                                                   input logic [7:0] b, input logic odd);
    mergeByte = odd ? {b, word[7:0]} : {word[15:8], b};
  endfunction
`endif

  // Accept-time decode: byte qualifier, alignment/range error, word-aligned address.
  always_comb begin
`ifdef BYTE_ACCESS_EN
    isByte = bus.req_byte;
`else
    isByte = 1'b0;
`endif
    reqErr      = (bus.req_addr[0] & ~isByte) |
                  ((bus.req_addr >> 1) >= ADDR_W'(MEM_WORDS));
    alignedAddr = {bus.req_addr[ADDR_W-1:1], 1'b0};
  end

  // Controller FSM; every bus output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRdata <= {DATA_W{1'b0}};
      respErr   <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      rdAddr    <= {ADDR_W{1'b0}};
      wrAddr    <= {ADDR_W{1'b0}};
      wrData    <= {DATA_W{1'b0}};
`ifdef BYTE_ACCESS_EN
      latByte   <= 1'b0;
      latOdd    <= 1'b0;
      latWbyte  <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          reqReady <= 1'b1;
          if (bus.req_valid) begin
            reqReady <= 1'b0;
`ifdef BYTE_ACCESS_EN
            latByte  <= isByte;
            latOdd   <= bus.req_addr[0];
            latWbyte <= bus.req_wdata[7:0];
`endif
            if (reqErr) begin
              // Rejected requests never touch the memory.
              state     <= RESP;
              respValid <= 1'b1;
              respErr   <= 1'b1;
              respRdata <= {DATA_W{1'b0}};
            end else if (bus.req_write) begin
`ifdef BYTE_ACCESS_EN
              if (isByte) begin
                state   <= RMW_RD;
                memRead <= 1'b1;
                rdAddr  <= alignedAddr;
              end else begin
                state    <= WR;
                memWrite <= 1'b1;
                wrAddr   <= bus.req_addr;
                wrData   <= bus.req_wdata;
              end
`else
              state    <= WR;
              memWrite <= 1'b1;
              wrAddr   <= bus.req_addr;
              wrData   <= bus.req_wdata;
`endif
            end else begin
              state   <= RD;
              memRead <= 1'b1;
              rdAddr  <= alignedAddr;
            end
          end
        end
        RD: begin
          memRead   <= 1'b0;
          respValid <= 1'b1;
          respErr   <= 1'b0;
`ifdef BYTE_ACCESS_EN
          respRdata <= latByte ? pickByte(bus.readData, latOdd) : bus.readData;
`else
          respRdata <= bus.readData;
`endif
          state     <= RESP;
        end
        WR: begin
          memWrite  <= 1'b0;
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respRdata <= {DATA_W{1'b0}};
          state     <= RESP;
        end
`ifdef BYTE_ACCESS_EN
        RMW_RD: begin
          memRead  <= 1'b0;
          memWrite <= 1'b1;
          wrAddr   <= rdAddr;
          wrData   <= mergeByte(bus.readData, latWbyte, latOdd);
          state    <= RMW_WR;
        end
        RMW_WR: begin
          memWrite  <= 1'b0;
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respRdata <= {DATA_W{1'b0}};
          state     <= RESP;
        end
`endif
        RESP: begin
          if (bus.resp_ready) begin
            respValid <= 1'b0;
            respErr   <= 1'b0;
            reqReady  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          reqReady  <= 1'b1;
          respValid <= 1'b0;
          respErr   <= 1'b0;
          memRead   <= 1'b0;
          memWrite  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready    = reqReady;
  assign bus.resp_valid   = respValid;
  assign bus.resp_rdata   = respRdata;
  assign bus.resp_err     = respErr;
  assign bus.MemRead      = memRead;
  assign bus.MemWrite     = memWrite;
  assign bus.readAddress  = rdAddr;
  assign bus.writeAddress = wrAddr;
  assign bus.writeData    = wrData;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator for the 16-bit data memory interface (MemRead/MemWrite, readAddress/writeAddress, writeData/readData).
- Accepts one load/store request at a time from the datapath over a valid/ready handshake and sequences the memory strobes.
- Captures read data and returns a response with an error flag.
- Sits between the execute stage and the data memory.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, byte-address width
- MEM_WORDS, 100, number of 16-bit words in the memory; word index is byte address >> 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data (low byte used for byte stores)
- req_byte  in  1  byte access; only used with BYTE_ACCESS_EN
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  request rejected (misaligned or out of range)
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- readAddress  out  ADDR_W  byte address to memory read port
- writeAddress  out  ADDR_W  byte address to memory write port
- writeData  out  DATA_W  word to memory write port
- readData  in  DATA_W  combinational read data from memory

Behaviour:
- Reset (async, active-high) forces the following immediately, with no response produced for an in-flight request:
  - state = IDLE
  - req_ready = 1 once reset deasserts
  - resp_valid, resp_err, MemRead, MemWrite = 0
  - resp_rdata, readAddress, writeAddress, writeData = 0
- States: IDLE, RD, WR, RESP; with the macro, also RMW_RD and RMW_WR.
- IDLE:
  - req_ready = 1; all other states drive req_ready = 0.
  - On the edge with req_valid = 1, latch write, addr, wdata and byte.
- Error check at accept:
  - Word access with addr[0] = 1 is an error.
  - (addr >> 1) >= MEM_WORDS is an error.
  - On error: go directly to RESP with resp_err = 1 and resp_rdata = 0; no strobe is ever asserted.
- Word load: IDLE -> RD.
  - RD lasts exactly 1 cycle: MemRead = 1, readAddress = latched addr.
  - readData is sampled at the end of RD into resp_rdata.
  - Then -> RESP.
- Word store: IDLE -> WR.
  - WR lasts exactly 1 cycle: MemWrite = 1, writeAddress = latched addr, writeData = latched wdata.
  - Then -> RESP with resp_rdata = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable until resp_ready = 1.
  - Then -> IDLE, and resp_valid drops on the next cycle.
- Latency: accept edge N, strobe cycle N+1, resp_valid from cycle N+2. Error responses appear from N+1.
- Throughput: at most one request per 3 cycles; no overlap of request and response.
- Address and data outputs hold their last driven value while strobes are low. MemRead and MemWrite are never high in the same cycle.
- req_valid while req_ready = 0 is ignored; the requester holds the request.

Optional Feature:
- Macro: BYTE_ACCESS_EN
- With the macro defined:
  - req_byte = 1 allows any address parity. The range check uses addr >> 1.
  - Even address selects [7:0]; odd address selects [15:8].
  - Byte load: RD as for a word, aligned address (addr & ~1). resp_rdata = selected byte zero-extended to 16 bits.
  - Byte store is a read-modify-write:
    - RMW_RD (1 cycle, MemRead = 1) captures the word.
    - RMW_WR (1 cycle, MemWrite = 1) writes the word with the selected byte replaced by req_wdata[7:0]; the other byte is unchanged.
    - Then -> RESP. Latency is one cycle longer than a word store.
- Without the macro: req_byte is ignored, every access is a word access, and odd addresses give resp_err.

Test Plan:
- Store 0xBEEF at 0x0010, then load 0x0010 -> one MemWrite pulse with writeAddress = 0x0010; load resp_rdata = 0xBEEF, resp_err = 0, resp_valid 2 cycles after each accept.
- After memory reset, load 0x0000 -> resp_rdata = 0x1BCD; load 0x0002 -> 0x0000.
- Load 0x0003 (word) and store to 0x00C8 (word 100) -> resp_err = 1, resp_rdata = 0, MemRead/MemWrite never asserted.
- Hold resp_ready = 0 for 5 cycles after a load of 0xBEEF -> resp_valid and resp_rdata remain 0xBEEF and req_ready stays 0; next accept only after resp_ready.
- Assert reset during the WR cycle of a store -> MemWrite drops immediately, no resp_valid, req_ready = 1 after reset release.
- With BYTE_ACCESS_EN: word 0x1234 at 0x0004, byte store 0x??AB to 0x0005 -> memory word = 0xAB34 (RMW_RD then RMW_WR); byte load 0x0005 -> 0x00AB; byte load 0x0004 -> 0x0034.
